// File: rtl/robot_master_fsm.sv
// Top-level behaviour controller for the washer-collecting robot: sequences search, avoid,
// grab, colour check, corner seek, drop and stall recovery with a stall fault lock-out.
module robot_master_fsm #(
    parameter int unsigned NUM_IR       = 2,
    parameter int unsigned NUM_SENSE    = 2,
    parameter int unsigned CS_W         = 3,
    parameter int unsigned GRAB_CYCLES  = 8,
    parameter int unsigned COLOR_CYCLES = 4,
    parameter int unsigned DROP_CYCLES  = 8,
    parameter int unsigned CLEAR_CYCLES = 4,
    parameter int unsigned MAX_STALLS   = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IR-1:0]    i_irs,
    input  logic [NUM_SENSE-1:0] i_sense,
    input  logic                 i_ips,
    input  logic [CS_W-1:0]      i_cs,
    input  logic                 i_pt,
    output logic                 o_enable_search,
    output logic                 o_enable_corner,
    output logic [NUM_IR-1:0]    o_avoid_mask,
    output logic                 o_emag_on,
    output logic                 o_servo_down,
    output logic [CS_W-1:0]      o_color_code,
    output logic [CNT_W-1:0]     o_washer_count,
    output logic [2:0]           o_state_code,
    output logic                 o_fault
);

    localparam int unsigned MaxDwellGc = (GRAB_CYCLES > COLOR_CYCLES) ? GRAB_CYCLES : COLOR_CYCLES;
    localparam int unsigned MaxDwell   = (MaxDwellGc > DROP_CYCLES) ? MaxDwellGc : DROP_CYCLES;
    localparam int unsigned TW = $clog2(MaxDwell) + 1;
    localparam int unsigned CW = $clog2(CLEAR_CYCLES + 1);
    localparam int unsigned SW = $clog2(MAX_STALLS + 1);

    typedef enum logic [2:0] {
        StSearch  = 3'd0,
        StAvoid   = 3'd1,
        StGrab    = 3'd2,
        StColor   = 3'd3,
        StCorner  = 3'd4,
        StDrop    = 3'd5,
        StStalled = 3'd6,
        StFault   = 3'd7
    } state_e;

    // Two-flop synchronisers
    logic [NUM_IR-1:0]    r_irs_meta, r_irs_sync;
    logic [NUM_SENSE-1:0] r_sense_meta, r_sense_sync;
    logic                 r_ips_meta, r_ips_sync;
    logic [CS_W-1:0]      r_cs_meta, r_cs_sync;
    logic                 r_pt_meta, r_pt_sync;

    state_e           r_state, w_state_d;
    state_e           r_ret, w_ret_d;
    logic [TW-1:0]    r_timer, w_timer_d;
    logic [CW-1:0]    r_clr, w_clr_d;
    logic [SW-1:0]    r_stall_cnt, w_stall_cnt_d;
    logic             r_emag, w_emag_d;
    logic [CS_W-1:0]  r_color, w_color_d;
    logic [CNT_W-1:0] r_count, w_count_d;

    logic              r_en_search, w_en_search;
    logic              r_en_corner, w_en_corner;
    logic [NUM_IR-1:0] r_avoid_mask, w_avoid_mask;
    logic              r_servo, w_servo;
    logic              r_fault, w_fault;

    logic w_stall, w_obstacle, w_washer;

    assign w_stall    = |r_sense_sync;
    assign w_obstacle = |r_irs_sync;
    assign w_washer   = ~r_ips_sync;

    always_comb begin
        w_state_d     = r_state;
        w_ret_d       = r_ret;
        w_timer_d     = r_timer;
        w_clr_d       = r_clr;
        w_stall_cnt_d = r_stall_cnt;
        w_emag_d      = r_emag;
        w_color_d     = r_color;
        w_count_d     = r_count;

        unique case (r_state)
            StSearch, StCorner: begin
                if (w_stall) begin
                    w_state_d = StStalled;
                    w_ret_d   = r_state;
                    w_clr_d   = '0;
                    if (r_stall_cnt < SW'(MAX_STALLS)) begin
                        w_stall_cnt_d = r_stall_cnt + 1'b1;
                    end
                end else if (w_obstacle) begin
                    w_state_d = StAvoid;
                    w_ret_d   = r_state;
                    w_clr_d   = '0;
                end else if (r_state == StSearch && w_washer) begin
                    w_state_d = StGrab;
                    w_timer_d = TW'(GRAB_CYCLES - 1);
                    w_emag_d  = 1'b1;
                end else if (r_state == StCorner && r_pt_sync) begin
                    w_state_d = StDrop;
                    w_timer_d = TW'(DROP_CYCLES - 1);
                end
            end
            StAvoid: begin
                if (w_stall) begin
                    w_state_d = StStalled;
                    w_clr_d   = '0;
                    if (r_stall_cnt < SW'(MAX_STALLS)) begin
                        w_stall_cnt_d = r_stall_cnt + 1'b1;
                    end
                end else if (w_obstacle) begin
                    w_clr_d = '0;
                end else if (r_clr == CW'(CLEAR_CYCLES - 1)) begin
                    w_state_d = r_ret;
                end else begin
                    w_clr_d = r_clr + 1'b1;
                end
            end
            StGrab: begin
                if (r_timer == '0) begin
                    w_state_d = StColor;
                    w_timer_d = TW'(COLOR_CYCLES - 1);
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            StColor: begin
                if (r_timer == '0) begin
                    w_color_d = r_cs_sync;
                    if (r_cs_sync != '0) begin
                        w_state_d = StCorner;
                    end else begin
                        w_state_d = StSearch;
                        w_emag_d  = 1'b0;
                    end
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            StDrop: begin
                if (r_timer == '0) begin
                    w_state_d     = StSearch;
                    w_emag_d      = 1'b0;
                    w_count_d     = r_count + 1'b1;
                    w_stall_cnt_d = '0;
                end else begin
                    w_timer_d = r_timer - 1'b1;
                end
            end
            StStalled: begin
                // The counter was bumped on entry, so the lock-out check sees this stall.
                if (r_stall_cnt >= SW'(MAX_STALLS)) begin
                    w_state_d = StFault;
                    w_emag_d  = 1'b0;
                end else if (w_stall) begin
                    w_clr_d = '0;
                end else if (r_clr == CW'(CLEAR_CYCLES - 1)) begin
                    w_state_d = r_ret;
                end else begin
                    w_clr_d = r_clr + 1'b1;
                end
            end
            StFault: begin
                w_emag_d = 1'b0;
            end
            default: begin
                w_state_d = StSearch;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with the state.
    always_comb begin
        w_en_search  = (w_state_d == StSearch);
        w_en_corner  = (w_state_d == StCorner);
        w_avoid_mask = (w_state_d == StAvoid) ? r_irs_sync : '0;
        w_servo      = (w_state_d == StGrab) || (w_state_d == StDrop);
        w_fault      = (w_state_d == StFault);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irs_meta   <= '0;
            r_irs_sync   <= '0;
            r_sense_meta <= '0;
            r_sense_sync <= '0;
            r_ips_meta   <= 1'b1;
            r_ips_sync   <= 1'b1;
            r_cs_meta    <= '0;
            r_cs_sync    <= '0;
            r_pt_meta    <= 1'b0;
            r_pt_sync    <= 1'b0;
            r_state      <= StSearch;
            r_ret        <= StSearch;
            r_timer      <= '0;
            r_clr        <= '0;
            r_stall_cnt  <= '0;
            r_emag       <= 1'b0;
            r_color      <= '0;
            r_count      <= '0;
            r_en_search  <= 1'b0;
            r_en_corner  <= 1'b0;
            r_avoid_mask <= '0;
            r_servo      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_irs_meta   <= i_irs;
            r_irs_sync   <= r_irs_meta;
            r_sense_meta <= i_sense;
            r_sense_sync <= r_sense_meta;
            r_ips_meta   <= i_ips;
            r_ips_sync   <= r_ips_meta;
            r_cs_meta    <= i_cs;
            r_cs_sync    <= r_cs_meta;
            r_pt_meta    <= i_pt;
            r_pt_sync    <= r_pt_meta;
            r_state      <= w_state_d;
            r_ret        <= w_ret_d;
            r_timer      <= w_timer_d;
            r_clr        <= w_clr_d;
            r_stall_cnt  <= w_stall_cnt_d;
            r_emag       <= w_emag_d;
            r_color      <= w_color_d;
            r_count      <= w_count_d;
            r_en_search  <= w_en_search;
            r_en_corner  <= w_en_corner;
            r_avoid_mask <= w_avoid_mask;
            r_servo      <= w_servo;
            r_fault      <= w_fault;
        end
    end

    assign o_enable_search = r_en_search;
    assign o_enable_corner = r_en_corner;
    assign o_avoid_mask    = r_avoid_mask;
    assign o_emag_on       = r_emag;
    assign o_servo_down    = r_servo;
    assign o_color_code    = r_color;
    assign o_washer_count  = r_count;
    assign o_state_code    = r_state;
    assign o_fault         = r_fault;

endmodule

// File: tb/tb_robot_master_fsm.sv
// Randomised bench for robot_master_fsm; a behavioural model predicts every registered output
// each cycle from the mission rules, with inputs delayed two edges to account for syncing.
module tb_robot_master_fsm;

    localparam int GRAB  = 8;
    localparam int COLOR = 4;
    localparam int DROP  = 8;
    localparam int CLEAR = 4;
    localparam int MAXST = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] irs = 2'b00;
    logic [1:0] sense = 2'b00;
    logic       ips = 1'b1;
    logic [2:0] cs = 3'b000;
    logic       pt = 1'b0;

    logic       enable_search, enable_corner, emag_on, servo_down, fault;
    logic [1:0] avoid_mask;
    logic [2:0] color_code, state_code;
    logic [7:0] washer_count;

    robot_master_fsm #(
        .NUM_IR      (2),
        .NUM_SENSE   (2),
        .CS_W        (3),
        .GRAB_CYCLES (GRAB),
        .COLOR_CYCLES(COLOR),
        .DROP_CYCLES (DROP),
        .CLEAR_CYCLES(CLEAR),
        .MAX_STALLS  (MAXST),
        .CNT_W       (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_irs          (irs),
        .i_sense        (sense),
        .i_ips          (ips),
        .i_cs           (cs),
        .i_pt           (pt),
        .o_enable_search(enable_search),
        .o_enable_corner(enable_corner),
        .o_avoid_mask   (avoid_mask),
        .o_emag_on      (emag_on),
        .o_servo_down   (servo_down),
        .o_color_code   (color_code),
        .o_washer_count (washer_count),
        .o_state_code   (state_code),
        .o_fault        (fault)
    );

    always #5 clk = ~clk;

    logic [20:0] act_vec, exp_vec;
    assign act_vec = {state_code, enable_search, enable_corner, avoid_mask, emag_on, servo_down,
                      color_code, washer_count, fault};

    int n_cmp  = 0;
    int n_fail = 0;

    // Mission model: mode numbers follow the published state codes
    logic [8:0] m_meta, m_sync;
    int m_mode, m_ret, m_age, m_run, m_stalls, m_emag, m_color, m_count;

    task automatic model_reset();
        m_mode = 0; m_ret = 0; m_age = 0; m_run = 0;
        m_stalls = 0; m_emag = 0; m_color = 0; m_count = 0;
        m_meta = {2'b00, 2'b00, 1'b1, 3'b000, 1'b0};
        m_sync = m_meta;
        exp_vec = '0;
    endtask

    task automatic model_step();
        logic [1:0] s_irs, s_sense;
        logic       s_ips, s_pt;
        logic [2:0] s_cs;
        int nxt;
        {s_irs, s_sense, s_ips, s_cs, s_pt} = m_sync;
        m_sync = m_meta;
        m_meta = {irs, sense, ips, cs, pt};
        nxt = m_mode;
        case (m_mode)
            0, 4: begin
                if (s_sense != 0) begin
                    m_ret = m_mode;
                    if (m_stalls < MAXST) m_stalls++;
                    nxt = 6;
                end else if (s_irs != 0) begin
                    m_ret = m_mode;
                    nxt = 1;
                end else if (m_mode == 0 && !s_ips) begin
                    m_emag = 1;
                    nxt = 2;
                end else if (m_mode == 4 && s_pt) begin
                    nxt = 5;
                end
            end
            1: begin
                if (s_sense != 0) begin
                    if (m_stalls < MAXST) m_stalls++;
                    nxt = 6;
                end else begin
                    m_run = (s_irs != 0) ? 0 : m_run + 1;
                    if (m_run == CLEAR) nxt = m_ret;
                end
            end
            2: begin
                m_age++;
                if (m_age == GRAB) nxt = 3;
            end
            3: begin
                m_age++;
                if (m_age == COLOR) begin
                    m_color = int'(s_cs);
                    if (s_cs != 0) nxt = 4;
                    else begin
                        m_emag = 0;
                        nxt = 0;
                    end
                end
            end
            5: begin
                m_age++;
                if (m_age == DROP) begin
                    m_emag = 0;
                    m_count = (m_count + 1) % 256;
                    m_stalls = 0;
                    nxt = 0;
                end
            end
            6: begin
                if (m_stalls >= MAXST) begin
                    m_emag = 0;
                    nxt = 7;
                end else begin
                    m_run = (s_sense != 0) ? 0 : m_run + 1;
                    if (m_run == CLEAR) nxt = m_ret;
                end
            end
            default: ;
        endcase
        if (nxt != m_mode) begin
            m_age = 0;
            m_run = 0;
        end
        m_mode = nxt;
        exp_vec = {3'(m_mode), m_mode == 0, m_mode == 4, (m_mode == 1) ? s_irs : 2'b00,
                   m_emag[0], (m_mode == 2 || m_mode == 5), 3'(m_color), 8'(m_count),
                   m_mode == 7};
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_reset();
        #3;
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        irs = 0; sense = 0; ips = 1; cs = 0; pt = 0;
        @(posedge clk);
        pulse_reset();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", act_vec, exp_vec);
        end
        release_reset();
        repeat (4) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reset_release: got %h want %h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_full_cycle();
        cs = 3'($urandom_range(1, 7));
        ips = 0;
        for (int i = 0; i < 60 && m_mode != 4; i++) begin
            tick();
            if (m_mode == 2) ips = 1;
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL grab_color: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (color_code !== cs) begin
            n_fail++;
            $display("FAIL color_latch: got %0d want %0d", color_code, cs);
        end
        pt = 1;
        for (int i = 0; i < 60 && m_mode != 0; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL corner_drop: got %h want %h", act_vec, exp_vec);
            end
        end
        pt = 0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL after_drop: got %h want %h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_color_reject();
        cs = 0;
        ips = 0;
        for (int i = 0; i < 60 && !(m_mode == 0 && m_age == 0 && i > 20); i++) begin
            tick();
            if (m_mode == 2) ips = 1;
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL color_reject: got %h want %h", act_vec, exp_vec);
            end
        end
        repeat (3) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL reject_idle: got %h want %h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_avoid_glitch();
        cs = 3'($urandom_range(1, 7));
        ips = 0;
        for (int i = 0; i < 60 && m_mode != 4; i++) begin
            tick();
            if (m_mode == 2) ips = 1;
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL avoid_setup: got %h want %h", act_vec, exp_vec);
            end
        end
        // obstacle, 3 clear, glitch, then clear until back in CORNER
        for (int i = 0; i < 40 && !(i > 10 && m_mode == 4); i++) begin
            if (i < 4) irs = 2'b10;
            else if (i == 7) irs = 2'($urandom_range(1, 3));
            else irs = 2'b00;
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL avoid_glitch: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (state_code !== 3'd4) begin
            n_fail++;
            $display("FAIL avoid_return: got %0d want 4", state_code);
        end
        pt = 1;
        for (int i = 0; i < 40 && m_mode != 0; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL avoid_drop: got %h want %h", act_vec, exp_vec);
            end
        end
        pt = 0;
    endtask

    task automatic test_stall_priority();
        sense = 2'b01;
        irs = 2'b11;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stall_prio: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (state_code !== 3'd6) begin
            n_fail++;
            $display("FAIL stall_not_avoid: got %0d want 6", state_code);
        end
        sense = 0;
        irs = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL stall_clear: got %h want %h", act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_fault();
        for (int i = 0; i < 200 && m_mode != 7; i++) begin
            sense = (i % 12 < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            irs = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL fault_entry: got %h want %h", act_vec, exp_vec);
            end
        end
        n_cmp++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_flag: got %b want 1", fault);
        end
        for (int i = 0; i < 30; i++) begin
            irs = 2'($urandom); sense = 2'($urandom); ips = 1'($urandom);
            cs = 3'($urandom); pt = 1'($urandom);
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL fault_hold: got %h want %h", act_vec, exp_vec);
            end
        end
        pulse_reset();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL fault_reset: got %h want %h", act_vec, exp_vec);
        end
        irs = 0; sense = 0; ips = 1; cs = 0; pt = 0;
        release_reset();
    endtask

    task automatic test_reset_mid_grab();
        ips = 0;
        for (int i = 0; i < 20 && !(m_mode == 2 && m_age == 3); i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL pre_grab: got %h want %h", act_vec, exp_vec);
            end
        end
        ips = 1;
        pulse_reset();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_mid_grab: got %h want %h", act_vec, exp_vec);
        end
        release_reset();
        tick();
        n_cmp++;
        if (act_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL grab_reset_release: got %h want %h", act_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            irs   = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            sense = ($urandom_range(0, 63) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ips   = ($urandom_range(0, 7) != 0);
            cs    = 3'($urandom);
            pt    = ($urandom_range(0, 3) == 0);
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_run: got %h want %h", act_vec, exp_vec);
            end
            if (m_mode == 7) begin
                pulse_reset();
                n_cmp++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL random_reset: got %h want %h", act_vec, exp_vec);
                end
                release_reset();
            end
        end
        irs = 0; sense = 0; ips = 1; cs = 0; pt = 0;
        repeat (30) tick();
        pulse_reset();
        release_reset();
    endtask

    task automatic test_count_wrap();
        ips = 0;
        pt = 1;
        cs = 3'($urandom_range(1, 7));
        for (int i = 0; i < 6000; i++) begin
            tick();
            n_cmp++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL count_wrap: got %h want %h", act_vec, exp_vec);
            end
        end
        ips = 1;
        pt = 0;
        repeat (40) tick();
        n_cmp++;
        if (washer_count !== 8'(m_count)) begin
            n_fail++;
            $display("FAIL count_final: got %0d want %0d", washer_count, m_count);
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        test_reset();
        test_full_cycle();
        test_color_reject();
        test_avoid_glitch();
        test_stall_priority();
        test_fault();
        test_reset_mid_grab();
        test_random();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/robot_master_fsm.md
# robot_master_fsm

Parametrised top-level behaviour controller for the washer-collecting robot. It takes N infrared obstacle sensors, M motor stall-sense lines, the inductive proximity sensor, the colour sensor bus and the corner phototransistor. It sequences search, avoid, grab, colour, corner, drop and stall recovery, and drives the enables for the search/corner drive modules, the electromagnet and the arm servo. It adds stall fault lock-out, timed grab/drop and a washer counter.

## Interface
- NUM_IR, 2, number of IR obstacle sensors
- NUM_SENSE, 2, number of stall-sense lines
- CS_W, 3, colour sensor code width
- GRAB_CYCLES, 8, servo-down dwell in GRAB
- COLOR_CYCLES, 4, colour settle time before sampling
- DROP_CYCLES, 8, servo-down dwell in DROP
- CLEAR_CYCLES, 4, consecutive clear cycles required to leave AVOID/STALLED
- MAX_STALLS, 3, stall entries before FAULT
- CNT_W, 8, washer counter width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- irs  in  NUM_IR  obstacle detected, active-high per bit
- sense  in  NUM_SENSE  motor stall, active-high per bit
- ips  in  1  proximity sensor, active-LOW (0 = washer present)
- cs  in  CS_W  colour code; 0 = no valid colour
- pt  in  1  corner marker detected, active-high
- enable_search  out  1  run search drive module
- enable_corner  out  1  run corner-seek drive module
- avoid_mask  out  NUM_IR  synchronised irs while in AVOID, else 0
- emag_on  out  1  electromagnet on
- servo_down  out  1  arm lowered
- color_code  out  CS_W  last latched colour
- washer_count  out  CNT_W  completed drops, wraps modulo 2^CNT_W
- state_code  out  3  current state
- fault  out  1  stall lock-out

## Operation
- All inputs pass through 2-flop synchronisers; the FSM uses only the synchronised values (ips inverted after sync → washer).
- States/encoding: SEARCH 0, AVOID 1, GRAB 2, COLOR 3, CORNER 4, DROP 5, STALLED 6, FAULT 7.
- stall = |sense; obstacle = |irs.
- SEARCH: enable_search=1. Priority stall → STALLED, else obstacle → AVOID, else washer → GRAB. ret_state ← SEARCH on leaving for AVOID/STALLED.
- CORNER: enable_corner=1. Priority stall → STALLED, else obstacle → AVOID, else pt → DROP. ret_state ← CORNER as above.
- AVOID: avoid_mask=irs. Stall → STALLED (ret_state unchanged). Once obstacle is clear for CLEAR_CYCLES consecutive cycles → ret_state. Any obstacle resets the clear counter.
- GRAB: emag_on=1, servo_down=1 for GRAB_CYCLES cycles, then → COLOR. Ignores sensors.
- COLOR: emag_on=1, servo up. After COLOR_CYCLES cycles, latch color_code←cs. If cs≠0 → CORNER, else emag_on←0 and → SEARCH.
- DROP: servo_down=1 for DROP_CYCLES cycles with emag_on=1. On the last cycle emag_on←0, washer_count+1, stall counter cleared, → SEARCH.
- STALLED: enable_search, enable_corner and servo_down are 0; emag_on holds its value. The stall counter increments on entry. If the counter reaches MAX_STALLS → FAULT. Otherwise, once stall is clear for CLEAR_CYCLES cycles → ret_state.
- FAULT: all outputs 0 except fault=1, color_code and washer_count hold. Only rst exits.
- Timers are one shared down-counter, width clog2(max dwell parameter)+1, loaded on state entry.

## Timing
- rst asserted: state SEARCH, every output 0, counters 0, ret_state SEARCH. Effect is immediate (async), mid-dwell included.
- The first rising edge after rst deasserts sets enable_search=1.
- Outputs are registered and change on the same edge as state_code.
- Input stable before edge E0 → sync at E1 → state/outputs change at E2.
- Dwell states occupy exactly their parameter count of cycles (GRAB_CYCLES=8 → state_code=2 for 8 cycles).
- Simultaneous stall and obstacle: stall wins. Simultaneous obstacle and washer/pt: obstacle wins.
- If an obstacle blips during the CLEAR_CYCLES window, the full window restarts.

## Test plan
- Reset release, no inputs → state_code 0 and enable_search=1 from the first edge. Hold rst mid-GRAB → all outputs 0 immediately.
- ips←0 in SEARCH → GRAB 2 cycles later: emag_on=1, servo_down=1 for 8 cycles. Then COLOR 4 cycles. cs=3'b101 → color_code=5, CORNER. pt=1 → DROP 8 cycles, washer_count=1, SEARCH.
- cs=0 at COLOR sample → emag_on=0, back to SEARCH, washer_count unchanged.
- irs=2'b10 in CORNER → AVOID with avoid_mask=2'b10. Clear for 3 cycles, glitch, clear for 4 → returns to CORNER (state 4).
- sense=2'b01 together with irs=2'b11 in SEARCH → STALLED, not AVOID. Clear for 4 cycles → SEARCH.
- Three stall entries without a drop → FAULT, fault=1, enable_* =0, stays there under all inputs until rst.
